exec_mdu_ctrl: RTL and testbench



---
 rtl/exec_mdu_ctrl_if.sv | 29 ++
 rtl/exec_mdu_ctrl.sv | 158 +++++++++++++++
 tb/tb_exec_mdu_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_mdu_ctrl_if.sv
// Issue/result bundle between the execute stage (master) and the multi-cycle
// multiply/divide sequencer (slave).
interface exec_mdu_ctrl_if #(
  parameter int XLEN = 64
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            kill_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic            zf_o;
  logic            sf_o;
  logic            of_o;
  logic            dz_o;

  modport master (
    output start_i, op_i, a_i, b_i, kill_i,
    input  stall_o, busy_o, done_o, result_o, zf_o, sf_o, of_o, dz_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, kill_i,
    output stall_o, busy_o, done_o, result_o, zf_o, sf_o, of_o, dz_o
  );
endinterface

// File: rtl/exec_mdu_ctrl.sv
// Multi-cycle mulq/divq/remq sequencer for the execute stage: shift-add multiply,
// restoring divide. Define MDU_EARLY_EXIT_EN to stop MUL once the multiplier runs out of set bits.
module exec_mdu_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  exec_mdu_ctrl_if.slave mdu
);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   divisor_q;
  logic [XLEN-1:0]   mplier_q;
  logic [XLEN-1:0]   quot_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   result_q;
  logic [2*XLEN-1:0] prod_q;
  logic [2*XLEN-1:0] mcand_q;
  logic              done_q, zf_q, sf_q, of_q, dz_q;

  logic              issue;
  logic              is_div_op;
  logic [2*XLEN-1:0] prod_nxt;
  logic [XLEN:0]     rem_shift;
  logic              div_ge;
  logic [XLEN-1:0]   rem_nxt;
  logic [XLEN-1:0]   quot_nxt;
  logic [XLEN-1:0]   div_res;
  logic [XLEN-1:0]   dz_res;
  logic              div_last;
  logic              mul_last;

  assign issue     = mdu.start_i && !mdu.kill_i;
  assign is_div_op = (mdu.op_i == 2'd1) || (mdu.op_i == 2'd2);
  assign dz_res    = (mdu.op_i == 2'd1) ? '1 : mdu.b_i;

  assign prod_nxt  = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

  // The partial remainder is always below the divisor once restored, so the
  // low XLEN bits of the subtraction are exact whenever div_ge holds.
  assign rem_shift = {rem_q, quot_q[XLEN-1]};
  assign div_ge    = (rem_shift >= {1'b0, divisor_q});
  assign rem_nxt   = div_ge ? (rem_shift[XLEN-1:0] - divisor_q) : rem_shift[XLEN-1:0];
  assign quot_nxt  = {quot_q[XLEN-2:0], div_ge};
  assign div_res   = (op_q == 2'd2) ? rem_nxt : quot_nxt;

  assign div_last  = (cnt_q == CNT_W'(1));
`ifdef MDU_EARLY_EXIT_EN
  assign mul_last  = div_last || (mplier_q[XLEN-1:1] == '0);
`else
  assign mul_last  = div_last;
`endif

  assign mdu.stall_o  = rst_n_i && !mdu.kill_i &&
                        ((state_q == ST_IDLE) ? mdu.start_i : (state_q != ST_DONE));
  assign mdu.busy_o   = (state_q != ST_IDLE);
  assign mdu.done_o   = done_q;
  assign mdu.result_o = result_q;
  assign mdu.zf_o     = zf_q;
  assign mdu.sf_o     = sf_q;
  assign mdu.of_o     = of_q;
  assign mdu.dz_o     = dz_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      divisor_q <= '0;
      mplier_q  <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      zf_q      <= 1'b0;
      sf_q      <= 1'b0;
      of_q      <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            op_q      <= mdu.op_i;
            divisor_q <= mdu.a_i;
            mplier_q  <= mdu.a_i;
            quot_q    <= mdu.b_i;
            rem_q     <= '0;
            prod_q    <= '0;
            mcand_q   <= {{XLEN{1'b0}}, mdu.b_i};
            cnt_q     <= CNT_W'(XLEN);
            if (!is_div_op) begin
              state_q <= ST_MUL;
            end else if (mdu.a_i == '0) begin
              result_q <= dz_res;
              zf_q     <= (dz_res == '0);
              sf_q     <= dz_res[XLEN-1];
              of_q     <= 1'b1;
              dz_q     <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              state_q <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          if (mdu.kill_i) begin
            state_q <= ST_IDLE;
          end else begin
            prod_q   <= prod_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CNT_W'(1);
            if (mul_last) begin
              result_q <= prod_nxt[XLEN-1:0];
              zf_q     <= (prod_nxt[XLEN-1:0] == '0);
              sf_q     <= prod_nxt[XLEN-1];
              of_q     <= |prod_nxt[2*XLEN-1:XLEN];
              dz_q     <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_DIV: begin
          if (mdu.kill_i) begin
            state_q <= ST_IDLE;
          end else begin
            rem_q  <= rem_nxt;
            quot_q <= quot_nxt;
            cnt_q  <= cnt_q - CNT_W'(1);
            if (div_last) begin
              result_q <= div_res;
              zf_q     <= (div_res == '0);
              sf_q     <= div_res[XLEN-1];
              of_q     <= 1'b0;
              dz_q     <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        // start_i here still belongs to the instruction just completed.
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_mdu_ctrl.sv
// Scoreboard bench for exec_mdu_ctrl: directed and random mul/div/rem ops, kill and
// mid-operation reset, checked against a plain-arithmetic reference model.
module tb_exec_mdu_ctrl;

  localparam int XLEN = 64;

  typedef struct {
    logic [63:0] res;
    logic        zf;
    logic        sf;
    logic        of;
    logic        dz;
    int          cyc;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc   = 0;
  int          checks = 0;
  int          fails  = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [63:0] last_res = '0;

  exec_mdu_ctrl_if #(.XLEN(XLEN)) mdu_if ();

  exec_mdu_ctrl #(.XLEN(XLEN), .CNT_W(7)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .mdu     (mdu_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: plain 128-bit product, native / and %, latency from the iteration rule.
  function automatic exp_t model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input int issue);
    exp_t         e;
    logic [127:0] p;
    int           lat;
    e.dz = 1'b0;
    e.of = 1'b0;
    lat  = XLEN;
    if (op == 2'd1 || op == 2'd2) begin
      if (a == 64'd0) begin
        e.dz  = 1'b1;
        e.of  = 1'b1;
        e.res = (op == 2'd1) ? {64{1'b1}} : b;
        lat   = 0;
      end else begin
        e.res = (op == 2'd1) ? (b / a) : (b % a);
      end
    end else begin
      p     = {64'd0, b} * {64'd0, a};
      e.res = p[63:0];
      e.of  = (p[127:64] != 64'd0);
`ifdef MDU_EARLY_EXIT_EN
      lat = 1;
      for (int i = 0; i < XLEN; i++) if (a[i]) lat = i + 1;
`endif
    end
    e.zf  = (e.res == 64'd0);
    e.sf  = e.res[63];
    e.cyc = issue + lat + 1;
    return e;
  endfunction

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && mdu_if.done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_done: done_o=1 with no operation outstanding (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("result", mdu_if.result_o, mon_e.res);
        checkOutput("zf", mdu_if.zf_o, mon_e.zf);
        checkOutput("sf", mdu_if.sf_o, mon_e.sf);
        checkOutput("of", mdu_if.of_o, mon_e.of);
        checkOutput("dz", mdu_if.dz_o, mon_e.dz);
        checkOutput("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        last_res = mon_e.res;
      end
    end
  end

  // Called at a negedge in an IDLE cycle; that cycle is the issue cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    mdu_if.start_i = 1'b1;
    mdu_if.kill_i  = 1'b0;
    mdu_if.op_i    = op;
    mdu_if.a_i     = a;
    mdu_if.b_i     = b;
    exp_q.push_back(model(op, a, b, cyc));
    #1;
    checkOutput("issue_stall", mdu_if.stall_o, 1'b1);
  endtask

  task automatic waitDone();
    int n   = 0;
    int bad = 0;
    @(negedge clk);
    while (mdu_if.done_o !== 1'b1 && n < 200) begin
      if (mdu_if.stall_o !== 1'b1 || mdu_if.busy_o !== 1'b1) bad++;
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      fails++;
      $display("[TB] FAIL done_timeout: no done_o within 200 cycles (cycle %0d)", cyc);
    end else begin
      checkOutput("stall_busy_during_op", 64'(bad), 64'd0);
      checkOutput("done_stall", mdu_if.stall_o, 1'b0);
      checkOutput("done_busy", mdu_if.busy_o, 1'b1);
    end
  endtask

  // Holds start through DONE like a stalled E stage, then releases it in the IDLE cycle.
  task automatic runOp(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    applyStimulus(op, a, b);
    waitDone();
    @(negedge clk);
    mdu_if.start_i = 1'b0;
    checkOutput("idle_after_done", mdu_if.busy_o, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},   mdu_if.busy_o,   1'b0);
    checkOutput({tag, "_done"},   mdu_if.done_o,   1'b0);
    checkOutput({tag, "_stall"},  mdu_if.stall_o,  1'b0);
    checkOutput({tag, "_result"}, mdu_if.result_o, 64'd0);
    checkOutput({tag, "_zf"},     mdu_if.zf_o,     1'b0);
    checkOutput({tag, "_sf"},     mdu_if.sf_o,     1'b0);
    checkOutput({tag, "_of"},     mdu_if.of_o,     1'b0);
    checkOutput({tag, "_dz"},     mdu_if.dz_o,     1'b0);
  endtask

  function automatic logic [63:0] randOperand();
    logic [63:0] v;
    case ($urandom_range(0, 3))
      0:       v = 64'd0;
      1:       v = 64'($urandom_range(1, 255));
      2:       v = {$urandom, $urandom};
      default: v = 64'd1 << $urandom_range(0, 63);
    endcase
    return v;
  endfunction

  initial begin
    logic [1:0]  rop;
    logic [63:0] ra, rb;

    mdu_if.start_i = 1'b0;
    mdu_if.kill_i  = 1'b0;
    mdu_if.op_i    = 2'd0;
    mdu_if.a_i     = '0;
    mdu_if.b_i     = '0;

    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    runOp(2'd0, 64'd3, 64'd7);
    runOp(2'd0, 64'd1 << 32, 64'd1 << 32);
    runOp(2'd0, {64{1'b1}}, 64'd1);
    applyStimulus(2'd1, 64'd7, 64'd100);
    waitDone();
    @(negedge clk);
    runOp(2'd2, 64'd7, 64'd100);
    runOp(2'd1, 64'd0, 64'd5);
    runOp(2'd2, 64'd0, 64'd5);
    runOp(2'd2, 64'd0, 64'd0);
    runOp(2'd3, 64'd5, 64'd6);
    runOp(2'd1, 64'd1, {64{1'b1}});

    // start together with kill in IDLE must not be accepted
    mdu_if.start_i = 1'b1;
    mdu_if.kill_i  = 1'b1;
    mdu_if.op_i    = 2'd0;
    mdu_if.a_i     = 64'd9;
    mdu_if.b_i     = 64'd9;
    #1;
    checkOutput("start_kill_stall", mdu_if.stall_o, 1'b0);
    @(negedge clk);
    checkOutput("start_kill_busy", mdu_if.busy_o, 1'b0);
    mdu_if.start_i = 1'b0;
    mdu_if.kill_i  = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = randOperand();
      rb  = ($urandom_range(0, 1) == 0) ? randOperand() : {$urandom, $urandom};
      runOp(rop, ra, rb);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // kill mid-multiply: top multiplier bit set so it is still iterating at cycle 20
    ra = {1'b1, 31'($urandom), $urandom};
    rb = {$urandom, $urandom};
    applyStimulus(2'd0, ra, rb);
    repeat (20) @(negedge clk);
    mdu_if.kill_i = 1'b1;
    #1;
    checkOutput("kill_stall", mdu_if.stall_o, 1'b0);
    checkOutput("kill_busy_still", mdu_if.busy_o, 1'b1);
    @(negedge clk);
    mdu_if.kill_i = 1'b0;
    checkOutput("kill_idle", mdu_if.busy_o, 1'b0);
    checkOutput("kill_result_held", mdu_if.result_o, last_res);
    void'(exp_q.pop_back());
    runOp(2'd2, 64'd13, {$urandom, $urandom});

    // asynchronous reset in the middle of a divide, start kept high across it
    ra = {1'b0, 31'($urandom), $urandom} | 64'd1;
    rb = {$urandom, $urandom};
    applyStimulus(2'd1, ra, rb);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkAllZero("midop_reset");
    void'(exp_q.pop_back());
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(model(2'd1, ra, rb, cyc));
    #1;
    checkOutput("reissue_stall", mdu_if.stall_o, 1'b1);
    waitDone();
    @(negedge clk);
    mdu_if.start_i = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
